nn_mlp_core: RTL

Parametrised two-layer perceptron inference engine and the next-generation replacement for the fixed 62-input network datapath/controller pair. It latches one input feature vector on `start` and computes a hidden layer (configurable activation) and an output layer, one multiply-accumulate per cycle, using weights fetched from an external synchronous ROM. It reports the arg-max class and its score with a level `network_ready`. It sits between the test-vector selector and the top-level result logic.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/nn_mlp_core_mac.sv | 40 ++++
 rtl/nn_mlp_core.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the two-layer perceptron core:
// FSM states, activation modes, weight-ROM address map and saturation.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_MAC,
    S_L1_ACT,
    S_L2_MAC,
    S_L2_CMP,
    S_DONE
  } state_t;

  localparam int ACT_RELU   = 0;
  localparam int ACT_LINEAR = 1;

  function automatic int rom_depth(input int n_in, input int n_hid, input int n_out);
    return n_hid * (n_in + 1) + n_out * (n_hid + 1);
  endfunction

  // Neuron-major layout with the bias word stored after the fan-in weights.
  function automatic int l1_addr(input int n_in, input int h, input int i);
    return h * (n_in + 1) + i;
  endfunction

  function automatic int l2_addr(input int n_in, input int n_hid, input int o, input int j);
    return n_hid * (n_in + 1) + o * (n_hid + 1) + j;
  endfunction

  function automatic longint sat_signed(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_mlp_core_mac.sv
// Signed multiply-accumulate with a bias path and a symmetric saturating accumulator.
module nn_mac
  import nn_pkg::*;
#(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 24,
  parameter int FRAC  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    bias,
  input  logic signed [DW-1:0]    a_in,
  input  logic signed [WW-1:0]    w_in,
  output logic signed [ACC_W-1:0] acc_out
);

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  longint term;
  longint base;

  always_comb begin
    term  = bias ? (longint'(w_in) <<< FRAC) : longint'(a_in) * longint'(w_in);
    base  = clr ? 64'sd0 : longint'(acc_q);
    acc_d = acc_q;
    if (en) acc_d = ACC_W'(sat_signed(base + term, -ACC_MAX, ACC_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_out = acc_q;

endmodule

// File: rtl/nn_mlp_core.sv
// Two-layer perceptron inference engine: one MAC per cycle against an external
// synchronous weight ROM, configurable hidden activation, arg-max over outputs.
module nn_mlp_core
  import nn_pkg::*;
#(
  parameter int N_IN     = 62,
  parameter int N_HID    = 30,
  parameter int N_OUT    = 10,
  parameter int DW       = 8,
  parameter int WW       = 8,
  parameter int ACC_W    = 24,
  parameter int FRAC     = 0,
  parameter int ACT_MODE = 0,
  localparam int AW      = $clog2(rom_depth(N_IN, N_HID, N_OUT))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_IN*DW-1:0]      x_data,
  output logic                    w_rd,
  output logic [AW-1:0]           w_addr,
  input  logic signed [WW-1:0]    w_data,
  output logic [7:0]              test_out,
  output logic signed [ACC_W-1:0] score_out,
  output logic                    network_ready,
  output logic                    busy
);

  localparam int K_MAX   = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KW      = $clog2(K_MAX + 2);
  localparam int N_MAX   = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int NW      = $clog2(N_MAX + 1);
  localparam longint HID_MAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint ACT_LO  = (ACT_MODE == ACT_LINEAR) ? -HID_MAX - 1 : 64'sd0;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NW-1:0]           n_q, n_d;
  logic signed [DW-1:0]    x_q [N_IN];
  logic signed [DW-1:0]    x_d [N_IN];
  logic signed [DW-1:0]    hid_q [N_HID];
  logic signed [DW-1:0]    hid_d [N_HID];
  logic                    rd_dly_q, rd_dly_d;
  logic                    clr_dly_q, clr_dly_d;
  logic                    bias_dly_q, bias_dly_d;
  logic signed [DW-1:0]    opnd_q, opnd_d;
  logic signed [ACC_W-1:0] max_q, max_d;
  logic [NW-1:0]           max_idx_q, max_idx_d;
  logic [7:0]              test_q, test_d;
  logic signed [ACC_W-1:0] score_q, score_d;
  logic                    ready_q, ready_d;

  logic signed [ACC_W-1:0] acc;
  logic                    l2;
  logic [KW-1:0]           fan_in;
  int                      addr_int;
  longint                  act;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    x_d       = x_q;
    hid_d     = hid_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    test_d    = test_q;
    score_d   = score_q;
    ready_d   = ready_q;

    l2       = (state_q == S_L2_MAC);
    fan_in   = l2 ? KW'(N_HID) : KW'(N_IN);
    w_rd     = ((state_q == S_L1_MAC) || l2) && (k_q <= fan_in);
    addr_int = l2 ? l2_addr(N_IN, N_HID, int'(n_q), int'(k_q))
                  : l1_addr(N_IN, int'(n_q), int'(k_q));
    w_addr   = w_rd ? AW'(addr_int) : '0;

    // ROM data lags the read by one cycle, so the MAC controls travel with it.
    rd_dly_d   = w_rd;
    clr_dly_d  = w_rd && (k_q == '0);
    bias_dly_d = w_rd && (k_q == fan_in);
    opnd_d     = '0;
    for (int i = 0; i < N_IN; i++)
      if (!l2 && (k_q == KW'(i))) opnd_d = x_q[i];
    for (int j = 0; j < N_HID; j++)
      if (l2 && (k_q == KW'(j))) opnd_d = hid_q[j];

    act = sat_signed(longint'(acc) >>> FRAC, ACT_LO, HID_MAX);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          test_d  = 8'(max_idx_q);
          score_d = max_q;
          ready_d = 1'b1;
        end
        if (start) begin
          for (int i = 0; i < N_IN; i++) x_d[i] = x_data[i*DW +: DW];
          k_d     = '0;
          n_d     = '0;
          ready_d = 1'b0;
          state_d = S_L1_MAC;
        end
      end
      S_L1_MAC, S_L2_MAC: begin
        if (k_q == fan_in + KW'(1)) begin
          k_d     = '0;
          state_d = l2 ? S_L2_CMP : S_L1_ACT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_L1_ACT: begin
        for (int j = 0; j < N_HID; j++)
          if (n_q == NW'(j)) hid_d[j] = DW'(act);
        if (n_q == NW'(N_HID - 1)) begin
          n_d     = '0;
          state_d = S_L2_MAC;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_L1_MAC;
        end
      end
      S_L2_CMP: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if ((n_q == '0) || (acc > max_q)) begin
          max_d     = acc;
          max_idx_d = n_q;
        end
        if (n_q == NW'(N_OUT - 1)) begin
          n_d     = '0;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_L2_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      n_q        <= '0;
      x_q        <= '{default: '0};
      hid_q      <= '{default: '0};
      rd_dly_q   <= 1'b0;
      clr_dly_q  <= 1'b0;
      bias_dly_q <= 1'b0;
      opnd_q     <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      test_q     <= '0;
      score_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      x_q        <= x_d;
      hid_q      <= hid_d;
      rd_dly_q   <= rd_dly_d;
      clr_dly_q  <= clr_dly_d;
      bias_dly_q <= bias_dly_d;
      opnd_q     <= opnd_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      test_q     <= test_d;
      score_q    <= score_d;
      ready_q    <= ready_d;
    end
  end

  nn_mac #(
    .DW    (DW),
    .WW    (WW),
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_dly_q),
    .en      (rd_dly_q),
    .bias    (bias_dly_q),
    .a_in    (opnd_q),
    .w_in    (w_data),
    .acc_out (acc)
  );

  assign test_out      = test_q;
  assign score_out     = score_q;
  assign network_ready = ready_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
